// File: rtl/decoder_round_driver_pkg.sv
// rtl/decoder_round_driver_pkg.sv - shared states, stream width and header layout
package decoder_round_driver_pkg;

  localparam int STREAM_WIDTH    = 32;
  localparam int HDR_TIMEOUT_BIT = 31;
  localparam int HDR_ITER_MSB    = 7;
  localparam int HDR_ITER_LSB    = 0;

  typedef enum logic [2:0] {
    LOAD,
    START,
    WAIT,
    HDR,
    CYC,
    ROOTS
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/decoder_round_driver_if.sv
// rtl/decoder_round_driver_if.sv - syndrome input stream and result output stream
interface decoder_round_driver_if;
  import decoder_round_driver_pkg::*;

  logic [STREAM_WIDTH-1:0] s_data;
  logic                    s_valid;
  logic                    s_ready;
  logic [STREAM_WIDTH-1:0] m_data;
  logic                    m_valid;
  logic                    m_ready;
  logic                    m_last;

  modport slave (
    input  s_data, s_valid, m_ready,
    output s_ready, m_data, m_valid, m_last
  );

  modport master (
    output s_data, s_valid, m_ready,
    input  s_ready, m_data, m_valid, m_last
  );

endinterface

// File: rtl/decoder_round_driver_result_serializer.sv
// rtl/decoder_round_driver_result_serializer.sv - picks the output word for the current state
module result_serializer
  import decoder_round_driver_pkg::*;
#(
  parameter int PU_COUNT      = 18,
  parameter int ADDRESS_WIDTH = 6,
  parameter int RIDX_W        = 5
) (
  input  state_t                              state,
  input  logic                                timed_out,
  input  logic [7:0]                          iter_cap,
  input  logic [31:0]                         cyc_cap,
  input  logic [ADDRESS_WIDTH*PU_COUNT-1:0]   roots_cap,
  input  logic [RIDX_W-1:0]                   root_idx,
  output logic [STREAM_WIDTH-1:0]             data,
  output logic                                valid,
  output logic                                last
);

  always_comb begin
    data  = '0;
    valid = 1'b0;
    last  = 1'b0;
    case (state)
      HDR: begin
        valid                             = 1'b1;
        data[HDR_TIMEOUT_BIT]             = timed_out;
        data[HDR_ITER_MSB:HDR_ITER_LSB]   = iter_cap;
      end
      CYC: begin
        valid = 1'b1;
        data  = cyc_cap;
      end
      ROOTS: begin
        valid                   = 1'b1;
        data[ADDRESS_WIDTH-1:0] = ADDRESS_WIDTH'(roots_cap >> (int'(root_idx) * ADDRESS_WIDTH));
        last                    = (root_idx == RIDX_W'(PU_COUNT - 1));
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/decoder_round_driver.sv
// rtl/decoder_round_driver.sv - loads a syndrome round, starts the decoder, streams back its result
module decoder_round_driver
  import decoder_round_driver_pkg::*;
#(
  parameter  int CODE_DISTANCE_X = 3,
  parameter  int CODE_DISTANCE_Z = 2,
  parameter  int TIMEOUT_CYCLES  = 65535,
  localparam int ROUNDS          = max_int(CODE_DISTANCE_X, CODE_DISTANCE_Z),
  localparam int PU_COUNT        = CODE_DISTANCE_X * CODE_DISTANCE_Z * ROUNDS,
  localparam int ADDRESS_WIDTH   = 3 * $clog2(ROUNDS),
  localparam int WORDS_IN        = (PU_COUNT + STREAM_WIDTH - 1) / STREAM_WIDTH
) (
  input  logic                              clk,
  input  logic                              reset,
  decoder_round_driver_if.slave             strm,
  output logic                              new_round_start,
  output logic [PU_COUNT-1:0]               measurements,
  input  logic                              result_valid,
  input  logic [7:0]                        iteration_counter,
  input  logic [31:0]                       cycle_counter,
  input  logic [ADDRESS_WIDTH*PU_COUNT-1:0] roots
);

  localparam int          WIDX_W       = $clog2(WORDS_IN + 1);
  localparam int          RIDX_W       = $clog2(PU_COUNT + 1);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_t                            state, state_nx;
  logic [WIDX_W-1:0]                 word_idx;
  logic [RIDX_W-1:0]                 root_idx;
  logic [31:0]                       tcount;
  logic                              timed_out;
  logic [7:0]                        iter_cap;
  logic [31:0]                       cyc_cap;
  logic [ADDRESS_WIDTH*PU_COUNT-1:0] roots_cap;
  logic [PU_COUNT-1:0]               meas_nx;

  logic load_hs, last_in, out_hs, timeout_hit, wait_done;

  // Handshake outputs are forced low while reset is held, not just after it.
  assign strm.s_ready    = (state == LOAD) & ~reset;
  assign new_round_start = (state == START) & ~reset;

  assign load_hs     = strm.s_valid & strm.s_ready;
  assign last_in     = (word_idx == WIDX_W'(WORDS_IN - 1));
  assign out_hs      = strm.m_valid & strm.m_ready;
  assign timeout_hit = (tcount == TIMEOUT_LAST);
  assign wait_done   = result_valid | timeout_hit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= LOAD;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      LOAD:    if (load_hs && last_in)         state_nx = START;
      START:                                   state_nx = WAIT;
      WAIT:    if (wait_done)                  state_nx = HDR;
      HDR:     if (out_hs)                     state_nx = CYC;
      CYC:     if (out_hs)                     state_nx = ROOTS;
      ROOTS:   if (out_hs && strm.m_last)      state_nx = LOAD;
      default:                                 state_nx = LOAD;
    endcase
  end

  // Bits of the last input word beyond PU_COUNT simply have no destination.
  always_comb begin
    meas_nx = measurements;
    for (int b = 0; b < PU_COUNT; b++) begin
      if (word_idx == WIDX_W'(b / STREAM_WIDTH)) meas_nx[b] = strm.s_data[b % STREAM_WIDTH];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_idx     <= '0;
      root_idx     <= '0;
      tcount       <= '0;
      timed_out    <= 1'b0;
      iter_cap     <= '0;
      cyc_cap      <= '0;
      roots_cap    <= '0;
      measurements <= '0;
    end else begin
      if (load_hs) begin
        measurements <= meas_nx;
        word_idx     <= last_in ? '0 : word_idx + 1'b1;
      end
      case (state)
        START: tcount <= '0;
        WAIT: begin
          tcount <= tcount + 32'd1;
          if (wait_done) begin
            roots_cap <= roots;
            iter_cap  <= iteration_counter;
            cyc_cap   <= cycle_counter;
            timed_out <= ~result_valid;
          end
        end
        ROOTS: if (out_hs) root_idx <= strm.m_last ? '0 : root_idx + 1'b1;
        default: ;
      endcase
    end
  end

  result_serializer #(
    .PU_COUNT      (PU_COUNT),
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .RIDX_W        (RIDX_W)
  ) u_serializer (
    .state     (state),
    .timed_out (timed_out),
    .iter_cap  (iter_cap),
    .cyc_cap   (cyc_cap),
    .roots_cap (roots_cap),
    .root_idx  (root_idx),
    .data      (strm.m_data),
    .valid     (strm.m_valid),
    .last      (strm.m_last)
  );

endmodule

// File: tb/tb_decoder_round_driver.sv
// tb/tb_decoder_round_driver.sv - scoreboard bench for decoder_round_driver
module tb_decoder_round_driver;

  localparam int PU  = 18;
  localparam int AW  = 6;
  localparam int TMO = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  decoder_round_driver_if bus();

  logic              new_round_start;
  logic [PU-1:0]     measurements;
  logic              result_valid;
  logic [7:0]        iteration_counter;
  logic [31:0]       cycle_counter;
  logic [AW*PU-1:0]  roots;

  decoder_round_driver #(
    .CODE_DISTANCE_X (3),
    .CODE_DISTANCE_Z (2),
    .TIMEOUT_CYCLES  (TMO)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .strm              (bus),
    .new_round_start   (new_round_start),
    .measurements      (measurements),
    .result_valid      (result_valid),
    .iteration_counter (iteration_counter),
    .cycle_counter     (cycle_counter),
    .roots             (roots)
  );

  int          errors = 0;
  int          checks = 0;
  int          pkt_words = 0;
  logic [32:0] exp_q[$];
  logic [32:0] exp_word;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired, got no event expected event", name);
  endtask

  task automatic push_word(input logic last, input logic [31:0] d);
    exp_q.push_back({last, d});
  endtask

  // Monitor: compares every accepted output word against the scoreboard.
  always @(negedge clk) begin
    if (reset) begin
      pkt_words = 0;
    end else if (bus.m_valid && bus.m_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got 0x%0h last=%0b expected no word", bus.m_data, bus.m_last);
      end else begin
        exp_word = exp_q.pop_front();
        check("out_data", 64'(bus.m_data), 64'(exp_word[31:0]));
        check("out_last", 64'(bus.m_last), 64'(exp_word[32]));
      end
      pkt_words = bus.m_last ? 0 : pkt_words + 1;
    end
  end

  task automatic send_word(input logic [31:0] d);
    int n;
    @(posedge clk); #1;
    bus.s_data  = d;
    bus.s_valid = 1'b1;
    n = 0;
    while (!bus.s_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) bound_fail("s_ready_wait");
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
  endtask

  task automatic check_start(input logic [PU-1:0] exp_meas);
    @(negedge clk);
    check("round_start_pulse", 64'(new_round_start), 64'd1);
    check("measurements", 64'(measurements), 64'(exp_meas));
    @(negedge clk);
    check("round_start_single", 64'(new_round_start), 64'd0);
  endtask

  // Called right after a posedge; scrambles decoder inputs once the pulse is over.
  task automatic pulse_rv();
    #1 result_valid = 1'b1;
    @(posedge clk); #1;
    result_valid      = 1'b0;
    iteration_counter = 8'hEE;
    cycle_counter     = 32'hFFFF_0000;
    roots             = '1;
  endtask

  task automatic wait_pkt_words(input int n);
    int k;
    k = 0;
    while (pkt_words != n && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 200) bound_fail("packet_word_wait");
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp_q.size() != 0 || pkt_words != 0) && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 300) bound_fail("packet_drain");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.s_data        = '0;
    bus.s_valid       = 1'b0;
    bus.m_ready       = 1'b1;
    result_valid      = 1'b0;
    iteration_counter = '0;
    cycle_counter     = '0;
    roots             = '0;

    #2;
    check("rst_s_ready", 64'(bus.s_ready), 64'd0);
    check("rst_m_valid", 64'(bus.m_valid), 64'd0);
    check("rst_m_last", 64'(bus.m_last), 64'd0);
    check("rst_m_data", 64'(bus.m_data), 64'd0);
    check("rst_round_start", 64'(new_round_start), 64'd0);
    check("rst_measurements", 64'(measurements), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("load_after_reset", 64'(bus.s_ready), 64'd1);

    // Normal round with a 3-cycle stall on root word 4.
    iteration_counter = 8'd5;
    cycle_counter     = 32'h0000_1234;
    for (int i = 0; i < PU; i++) roots[i*AW +: AW] = AW'(i);
    push_word(1'b0, 32'h0000_0005);
    push_word(1'b0, 32'h0000_1234);
    for (int i = 0; i < PU; i++) push_word(i == PU - 1, 32'(i));
    send_word(32'hFFFF_FFFF);
    check_start(18'h3FFFF);
    repeat (9) @(posedge clk);
    pulse_rv();
    check("meas_stable", 64'(measurements), 64'h3FFFF);
    wait_pkt_words(6);
    bus.m_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("stall_valid", 64'(bus.m_valid), 64'd1);
      check("stall_data", 64'(bus.m_data), 64'd4);
      check("stall_last", 64'(bus.m_last), 64'd0);
    end
    @(posedge clk); #1;
    bus.m_ready = 1'b1;
    drain();

    // Timeout round: no result_valid at all.
    iteration_counter = 8'h3C;
    cycle_counter     = 32'hDEAD_BEEF;
    for (int i = 0; i < PU; i++) roots[i*AW +: AW] = AW'(63 - i);
    push_word(1'b0, 32'h8000_003C);
    push_word(1'b0, 32'hDEAD_BEEF);
    for (int i = 0; i < PU; i++) push_word(i == PU - 1, 32'(63 - i));
    send_word(32'h0000_00A5);
    check_start(18'h000A5);
    drain();

    // result_valid in LOAD is ignored.
    @(posedge clk); #1;
    result_valid      = 1'b1;
    iteration_counter = 8'h77;
    @(posedge clk); #1;
    result_valid = 1'b0;
    repeat (8) begin
      @(negedge clk);
      check("no_output_in_load", 64'(bus.m_valid), 64'd0);
    end

    // result_valid on the exact timeout cycle wins; upper input bits discarded.
    iteration_counter = 8'd9;
    cycle_counter     = 32'd7;
    for (int i = 0; i < PU; i++) roots[i*AW +: AW] = AW'((i * 5) % 64);
    push_word(1'b0, 32'h0000_0009);
    push_word(1'b0, 32'h0000_0007);
    for (int i = 0; i < PU; i++) push_word(i == PU - 1, 32'((i * 5) % 64));
    send_word(32'hFFFC_0001);
    check_start(18'h00001);
    repeat (15) @(posedge clk);
    pulse_rv();
    drain();

    // Reset during root word 7 aborts the packet.
    iteration_counter = 8'h42;
    cycle_counter     = 32'h0000_CAFE;
    for (int i = 0; i < PU; i++) roots[i*AW +: AW] = AW'(i);
    push_word(1'b0, 32'h0000_0042);
    push_word(1'b0, 32'h0000_CAFE);
    for (int i = 0; i < PU; i++) push_word(i == PU - 1, 32'(i));
    send_word(32'h0001_5555);
    check_start(18'h15555);
    repeat (2) @(posedge clk);
    pulse_rv();
    wait_pkt_words(9);
    check("pre_reset_word7", 64'(bus.m_data), 64'd7);
    reset = 1'b1;
    #1;
    check("abort_m_valid", 64'(bus.m_valid), 64'd0);
    check("abort_m_last", 64'(bus.m_last), 64'd0);
    check("abort_m_data", 64'(bus.m_data), 64'd0);
    check("abort_s_ready", 64'(bus.s_ready), 64'd0);
    check("abort_round_start", 64'(new_round_start), 64'd0);
    check("abort_measurements", 64'(measurements), 64'd0);
    exp_q.delete();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("restart_s_ready", 64'(bus.s_ready), 64'd1);
    check("restart_m_valid", 64'(bus.m_valid), 64'd0);

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decoder_round_driver.md
DECODER_ROUND_DRIVER -- requirements
Module: decoder_round_driver

Interface
REQ-001 The module SHALL have parameter CODE_DISTANCE_X, default 3, X code distance.
REQ-002 The module SHALL have parameter CODE_DISTANCE_Z, default 2, Z code distance.
REQ-003 The module SHALL have parameter TIMEOUT_CYCLES, default 65535, maximum number of WAIT cycles before abort.
REQ-004 The module SHALL derive ROUNDS = max(CODE_DISTANCE_X, CODE_DISTANCE_Z), PU_COUNT = CODE_DISTANCE_X*CODE_DISTANCE_Z*ROUNDS, ADDRESS_WIDTH = 3*clog2(ROUNDS) and WORDS_IN = ceil(PU_COUNT/32).
REQ-005 The module SHALL have port clk, input, 1 bit, the single clock.
REQ-006 The module SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-007 The module SHALL have ports s_data (input, 32 bits), s_valid (input, 1 bit) and s_ready (output, 1 bit), forming the syndrome input stream.
REQ-008 The module SHALL have output new_round_start, 1 bit, decoder round-start pulse.
REQ-009 The module SHALL have output measurements, PU_COUNT bits, the syndrome vector presented to the decoder.
REQ-010 The module SHALL have inputs result_valid (1 bit), iteration_counter (8 bits), cycle_counter (32 bits) and roots (ADDRESS_WIDTH*PU_COUNT bits), all driven by the decoder.
REQ-011 The module SHALL have ports m_data (output, 32 bits), m_valid (output, 1 bit), m_ready (input, 1 bit) and m_last (output, 1 bit), forming the result output stream.

Function
REQ-012 The state machine SHALL have states LOAD, START, WAIT, HDR, CYC and ROOTS, and SHALL reset to LOAD.
REQ-013 s_ready SHALL be 1 only in state LOAD.
REQ-014 In LOAD, the k-th accepted input word (handshake is s_valid & s_ready) SHALL be written into measurements[32k +: 32], with bits at index PU_COUNT and above discarded.
REQ-015 After the WORDS_IN-th handshake, the state machine SHALL move to START and the word index SHALL clear.
REQ-016 In START, new_round_start SHALL be 1 for exactly one cycle, and the next state SHALL be WAIT.
REQ-017 measurements SHALL hold stable from START until the next LOAD write.
REQ-018 In WAIT, a 32-bit timeout counter SHALL increment each cycle, and the first cycle with result_valid=1 SHALL capture roots, iteration_counter and cycle_counter, clear the timeout flag and move to HDR.
REQ-019 If the timeout counter reaches TIMEOUT_CYCLES without result_valid, the module SHALL capture the current inputs, set the timeout flag and move to HDR.
REQ-020 If result_valid and timeout occur in the same cycle, result_valid SHALL win and the timeout flag SHALL be 0.
REQ-021 result_valid SHALL be ignored in every state except WAIT.
REQ-022 m_valid SHALL be 1 in HDR, CYC and ROOTS only, and each state SHALL advance only on m_valid & m_ready.
REQ-023 m_data and m_last SHALL stay stable while m_valid=1 and m_ready=0.
REQ-024 In HDR, m_data SHALL equal {timeout flag, 23'b0, captured iteration_counter}.
REQ-025 In CYC, m_data SHALL equal the captured cycle_counter.
REQ-026 In ROOTS, word i (i = 0 .. PU_COUNT-1) SHALL be captured roots[i*ADDRESS_WIDTH +: ADDRESS_WIDTH], zero-extended to 32 bits.
REQ-027 m_last SHALL be 1 on word PU_COUNT-1 only, and acceptance of that word SHALL return the state machine to LOAD.
REQ-028 The output packet SHALL always contain PU_COUNT+2 words.

Reset
REQ-029 On reset assertion, state, word and root indices, timeout counter, timeout flag, captured registers and measurements SHALL clear asynchronously.
REQ-030 During reset, new_round_start, s_ready, m_valid and m_last SHALL be 0 and m_data SHALL be 0.
REQ-031 Reset asserted mid-packet SHALL abort the packet without asserting m_last, and the module SHALL restart in LOAD.

Structure
REQ-032 The state encoding, STREAM_WIDTH=32 and the header bit positions (timeout flag = bit 31, iteration field = bits 7:0) SHALL be defined in a shared package.
REQ-033 The output word selection and m_last generation SHALL be in one sub-module, result_serializer.

Verification
REQ-034 Directed test: with default parameters (PU_COUNT=18, ADDRESS_WIDTH=6, WORDS_IN=1), sending s_data=0xFFFF_FFFF SHALL give measurements=18'h3FFFF and a single new_round_start pulse on the cycle after the handshake.
REQ-035 Directed test: result_valid 10 cycles after START with iteration_counter=5, cycle_counter=0x1234 and roots[i]=i SHALL give the output words 0x0000_0005, 0x0000_1234, 0..17, with m_last on the 20th word only.
REQ-036 Directed test: holding m_ready=0 for 3 cycles during ROOTS word 4 SHALL keep m_data=4 and m_valid=1 unchanged for those cycles.
REQ-037 Directed test: with TIMEOUT_CYCLES=16 and no result_valid, the header SHALL be 0x8000_0000 | iteration_counter and the packet SHALL still contain 20 words.
REQ-038 Directed test: a result_valid pulse in LOAD SHALL produce no output words, while a later valid round SHALL produce a normal packet.
REQ-039 Directed test: reset asserted during ROOTS word 7 SHALL drop m_valid asynchronously, and s_ready SHALL be 1 in the first cycle after release.
